// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, PC width and reset vector.
package cpu_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; drop the byte offset of any target.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one redirect target that arrived while imem was not accepting fetches.
module pc_redirect_buf
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            clr,
    output logic            pend_vld,
    output logic [PC_W-1:0] pend_pc
);

    logic            vld_reg;
    logic [PC_W-1:0] pc_reg;

    // A newer redirect simply overwrites the older one; clear wins over write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_reg <= 1'b0;
        end else if (wr_en) begin
            vld_reg <= 1'b1;
        end
        if (!rst && !clr && wr_en) begin
            pc_reg <= wr_pc;
        end
    end

    assign pend_vld = vld_reg;
    assign pend_pc  = pc_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: warm-up/run/halt FSM, next-PC selection and IF/ID, ID/EX flush/hold decode.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int              WARMUP_CYCLES = 1,
    parameter logic [PC_W-1:0] PC_STEP       = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jmp_target_i,
    input  logic            halt_i,
    input  logic            imem_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic            fetch_req_o,
    output logic            flush_ifid_o,
    output logic            flush_idex_o,
    output logic            hold_ifid_o,
    output logic [1:0]      state_o
);

    localparam fetch_state_t RESET_STATE = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
    localparam logic [3:0]   WARMUP_INIT = 4'(WARMUP_CYCLES);

    fetch_state_t    state_reg;
    logic [3:0]      cnt_reg;
    logic [PC_W-1:0] pc_reg;
    logic            fetch_req_reg;

    logic            run;
    logic            accept;
    logic            jmp_eff;
    logic            redir_vld;
    logic [PC_W-1:0] redir_pc;
    logic            pend_vld;
    logic [PC_W-1:0] pend_pc;
    logic [PC_W-1:0] pc_next;

    assign run       = (state_reg == ST_RUN);
    assign accept    = run & fetch_req_reg & imem_ready_i;
    // A stalled or branch-squashed jump is dropped here; ID keeps presenting it.
    assign jmp_eff   = jmp_i & ~stall_i & ~br_taken_i;
    assign redir_vld = br_taken_i | jmp_eff;
    assign redir_pc  = br_taken_i ? align_pc(br_target_i) : align_pc(jmp_target_i);

    pc_redirect_buf u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (run & ~halt_i & ~accept & redir_vld),
        .wr_pc    (redir_pc),
        .clr      (run & (halt_i | accept)),
        .pend_vld (pend_vld),
        .pend_pc  (pend_pc)
    );

    always_comb begin
        pc_next = pc_reg + PC_STEP;
        if (redir_vld) begin
            pc_next = redir_pc;
        end else if (pend_vld) begin
            pc_next = pend_pc;
        end else if (stall_i) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RESET_STATE;
            cnt_reg       <= WARMUP_INIT;
            pc_reg        <= RESET_PC;
            fetch_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_WARMUP: begin
                    if (cnt_reg <= 4'd1) begin
                        state_reg     <= ST_RUN;
                        fetch_req_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        state_reg     <= ST_HALT;
                        fetch_req_reg <= 1'b0;
                    end else begin
                        fetch_req_reg <= 1'b1;
                        if (accept) begin
                            pc_reg <= pc_next;
                        end
                    end
                end
                ST_HALT: begin
                    fetch_req_reg <= 1'b0;
                end
                default: begin
                    state_reg     <= ST_HALT;
                    fetch_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o         = pc_reg;
    assign fetch_req_o  = fetch_req_reg;
    assign state_o      = state_reg;
    assign flush_ifid_o = run & (redir_vld | (accept & pend_vld));
    assign flush_idex_o = run & br_taken_i;
    assign hold_ifid_o  = run & stall_i & ~br_taken_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed cycle-by-cycle bench for pc_sequencer with a queue of expected observations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, br_taken_i, jmp_i, halt_i, imem_ready_i;
    logic [31:0] br_target_i, jmp_target_i;
    logic [31:0] pc_o;
    logic        fetch_req_o, flush_ifid_o, flush_idex_o, hold_ifid_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_WU = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        fetch;
        logic        fi;
        logic        fx;
        logic        hold;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .WARMUP_CYCLES (1),
        .PC_STEP       (32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .halt_i       (halt_i),
        .imem_ready_i (imem_ready_i),
        .pc_o         (pc_o),
        .fetch_req_o  (fetch_req_o),
        .flush_ifid_o (flush_ifid_o),
        .flush_idex_o (flush_idex_o),
        .hold_ifid_o  (hold_ifid_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, queue the expected outputs, compare mid-cycle, advance.
    task automatic cyc(input string tag, input logic r, input logic st, input logic br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt,
                       input logic h, input logic rdy,
                       input logic [31:0] e_pc, input logic e_f, input logic e_fi,
                       input logic e_fx, input logic e_hold, input logic [1:0] e_st);
        exp_t e;
        rst = r; stall_i = st; br_taken_i = br; br_target_i = bt;
        jmp_i = j; jmp_target_i = jt; halt_i = h; imem_ready_i = rdy;
        sb.push_back('{tag, e_pc, e_f, e_fi, e_fx, e_hold, e_st});
        @(negedge clk);
        e = sb.pop_front();
        $display("%-12s pc=%h req=%b fl_ifid=%b fl_idex=%b hold=%b st=%0d",
                 e.tag, pc_o, fetch_req_o, flush_ifid_o, flush_idex_o, hold_ifid_o, state_o);
        chk(e.tag, "pc",    pc_o,                  e.pc);
        chk(e.tag, "req",   {31'd0, fetch_req_o},  {31'd0, e.fetch});
        chk(e.tag, "fifid", {31'd0, flush_ifid_o}, {31'd0, e.fi});
        chk(e.tag, "fidex", {31'd0, flush_idex_o}, {31'd0, e.fx});
        chk(e.tag, "hold",  {31'd0, hold_ifid_o},  {31'd0, e.hold});
        chk(e.tag, "state", {30'd0, state_o},      {30'd0, e.st});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 0; br_taken_i = 0; br_target_i = 0;
        jmp_i = 0; jmp_target_i = 0; halt_i = 0; imem_ready_i = 1;
        repeat (2) @(posedge clk);
        #1;
        //   tag            rst stl br bt            jmp jt            hlt rdy   pc            req fi fx hd st
        cyc("reset",        0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h0,        0,  0, 0, 0, S_WU);
        cyc("run0",         0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h0,        1,  0, 0, 0, S_RUN);
        cyc("seq4",         0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h4,        1,  0, 0, 0, S_RUN);
        cyc("seq8",         0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h8,        1,  0, 0, 0, S_RUN);
        cyc("seqC",         0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'hC,        1,  0, 0, 0, S_RUN);
        cyc("stall1",       0,  1,  0, 32'h0,        0,  32'h0,        0,  1,    32'h10,       1,  0, 0, 1, S_RUN);
        cyc("stall_jmp",    0,  1,  0, 32'h0,        1,  32'h300,      0,  1,    32'h10,       1,  0, 0, 1, S_RUN);
        cyc("unstall",      0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h10,       1,  0, 0, 0, S_RUN);
        cyc("seq14",        0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h14,       1,  0, 0, 0, S_RUN);
        cyc("seq18",        0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h18,       1,  0, 0, 0, S_RUN);
        cyc("seq1C",        0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h1C,       1,  0, 0, 0, S_RUN);
        cyc("br_jmp",       0,  1,  1, 32'h103,      1,  32'h500,      0,  1,    32'h20,       1,  1, 1, 0, S_RUN);
        cyc("jmp40",        0,  0,  0, 32'h0,        1,  32'h42,       0,  1,    32'h100,      1,  1, 0, 0, S_RUN);
        cyc("nrdy_jmp",     0,  0,  0, 32'h0,        1,  32'h80,       0,  0,    32'h40,       1,  1, 0, 0, S_RUN);
        cyc("nrdy_w1",      0,  0,  0, 32'h0,        0,  32'h0,        0,  0,    32'h40,       1,  0, 0, 0, S_RUN);
        cyc("nrdy_w2",      0,  0,  0, 32'h0,        0,  32'h0,        0,  0,    32'h40,       1,  0, 0, 0, S_RUN);
        cyc("pend_acc",     0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h40,       1,  1, 0, 0, S_RUN);
        cyc("at80",         0,  0,  0, 32'h0,        1,  32'hFFFF_FFFC,0,  1,    32'h80,       1,  1, 0, 0, S_RUN);
        cyc("top",          0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'hFFFF_FFFC,1,  0, 0, 0, S_RUN);
        cyc("wrap",         0,  0,  0, 32'h0,        1,  32'h30,       0,  1,    32'h0,        1,  1, 0, 0, S_RUN);
        cyc("halt_br",      0,  0,  1, 32'h200,      0,  32'h0,        1,  1,    32'h30,       1,  1, 1, 0, S_RUN);
        cyc("halted1",      0,  1,  1, 32'h400,      1,  32'h600,      0,  1,    32'h30,       0,  0, 0, 0, S_HALT);
        cyc("halted2",      0,  0,  0, 32'h0,        1,  32'h600,      1,  1,    32'h30,       0,  0, 0, 0, S_HALT);
        cyc("halt_rst",     1,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h30,       0,  0, 0, 0, S_HALT);
        cyc("warm2",        0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h0,        0,  0, 0, 0, S_WU);
        cyc("run2",         0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h0,        1,  0, 0, 0, S_RUN);
        cyc("pend2",        0,  0,  0, 32'h0,        1,  32'h80,       0,  0,    32'h4,        1,  1, 0, 0, S_RUN);
        cyc("rst_pend",     1,  0,  0, 32'h0,        0,  32'h0,        0,  0,    32'h4,        1,  0, 0, 0, S_RUN);
        cyc("warm3",        0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h0,        0,  0, 0, 0, S_WU);
        cyc("run3",         0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h0,        1,  0, 0, 0, S_RUN);
        cyc("no_pend",      0,  0,  0, 32'h0,        0,  32'h0,        0,  1,    32'h4,        1,  0, 0, 0, S_RUN);
        chk("scoreboard", "left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
